dual_priodec_frame: RTL and testbench
=====================================

// Module: dual_priodec_frame
// PURPOSE
//  Inverse of the team's dual priority encoder. Accepts a stream of encoded code pairs
//  {first, second} (1-based bit index, 0 = none) over a valid/ready handshake.
//  Decodes each pair back to a one-hot-OR bit mask and ORs the masks of all beats of a frame.
//  Presents the rebuilt request vector, a beat count and an error flag on a registered output handshake.
//  Sits downstream of the encoder to rebuild request vectors on the receiving side and to check them.
// PARAMETERS
//  WIDTH  12  width of the rebuilt mask; legal codes are 1..WIDTH
//  CW      4  code width; 2**CW > WIDTH is required
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      code pair present
//  in_ready   out  1      block can accept a pair this cycle
//  first      in   CW     highest-priority code (1-based, 0 = none)
//  second     in   CW     next-priority code (1-based, 0 = none)
//  in_last    in   1      final beat of the frame
//  out_valid  out  1      frame result available
//  out_ready  in   1      consumer takes the result
//  out_mask   out  WIDTH  OR of the decoded bits of every beat in the frame
//  out_beats  out  8      beats accepted in the frame, saturates at 255
//  out_err    out  1      at least one beat in the frame was malformed
// BEHAVIOUR
//  Reset:
//   - state=IDLE; acc, err_acc, beat_cnt cleared.
//   - out_valid=0, out_mask=0, out_beats=0, out_err=0.
//   - A reset mid-frame or mid-output discards all partial and pending data.
//  Accept:
//   - A beat is accepted when in_valid & in_ready.
//   - in_ready=1 in IDLE and ACCUM, 0 in OUT. in_ready is a function of state only.
//  Decode per beat:
//   - dec(c) = (c in 1..WIDTH) ? 1<<(c-1) : 0.
//   - beat_mask = dec(first) | dec(second).
//  Beat is malformed (sets err_acc) if any of:
//   - first > WIDTH, or second > WIDTH (the out-of-range code contributes no bit);
//   - second != 0 while first == 0;
//   - first != 0 and second != 0 and second >= first.
//   - In-range codes of a malformed beat are still decoded into the mask.
//  State machine:
//   - IDLE:  accept, no last   -> ACCUM (acc=beat_mask, beat_cnt=1).
//   - IDLE:  accept with last  -> OUT.
//   - ACCUM: accept            -> acc|=beat_mask, beat_cnt+=1 (saturating); last -> OUT.
//   - ACCUM: no accept         -> hold; no timeout.
//   - OUT:   out_ready         -> IDLE; clear acc, err_acc, beat_cnt.
//  Output:
//   - On the accepted last beat, the out_* registers load in that same edge:
//     out_mask = acc|beat_mask (acc taken as 0 from IDLE), plus beat count and error.
//   - Latency: out_valid=1 the cycle after the last-beat handshake.
//   - out_* stay stable while out_valid & !out_ready.
//   - out_valid drops the cycle after the out handshake. The next frame may start on that cycle.
//   - No input acceptance in OUT, so the minimum frame period is 2 cycles.
//  A frame of one (0,0,last) beat is legal: mask 0, beats 1, err 0.
//  Input-side values other than in_valid are ignored when in_valid=0.
// TESTING
//  T1: (first=12, second=3, last) -> next cycle out_valid=1, mask=0x804, beats=1, err=0.
//  T2: (5,0) then (9,1,last) -> mask=0x111, beats=2, err=0; in_ready high throughout.
//  T3: (3,7,last) -> mask=0x044, err=1; (13,2,last) -> mask=0x002, err=1; (0,4,last) -> mask=0x008, err=1.
//  T4: hold out_ready=0 for 5 cycles after T1 -> out_* stable, in_ready=0, offered beats not accepted;
//      release -> out_valid low next cycle.
//  T5: reset after one beat (6,2) -> then (1,0,last) -> mask=0x001, beats=1.
//  T6: (0,0,last) -> mask=0, beats=1, err=0; 300-beat frame of (1,0) -> beats=255.

Source files
------------

// File: rtl/dual_priodec_frame.sv
// Rebuilds request masks from {first, second} code-pair beats and reports
// one OR-ed mask, beat count and malformed flag per frame.
module dual_priodec_frame #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    first,
  input  logic [CW-1:0]    second,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [7:0]       out_beats,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [CW-1:0] CODE_MAX = CW'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             err_acc, err_acc_nxt;
  logic [7:0]       beat_cnt, beat_cnt_nxt;
  logic [WIDTH-1:0] out_mask_nxt;
  logic [7:0]       out_beats_nxt;
  logic             out_err_nxt;

  logic [WIDTH-1:0] beat_mask;
  logic             beat_bad;
  logic             accept;
  logic [WIDTH-1:0] acc_base, merged_mask;
  logic [7:0]       cnt_base, merged_cnt;
  logic             err_base, merged_err;

  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);
  assign accept    = in_valid & in_ready;

  always_comb begin
    beat_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if ((first == CW'(i + 1)) || (second == CW'(i + 1))) begin
        beat_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    beat_bad = (first > CODE_MAX) || (second > CODE_MAX)
            || ((second != '0) && (first == '0))
            || ((first != '0) && (second != '0) && (second >= first));
  end

  // Accumulators are treated as empty outside ACCUM so the first beat of a
  // frame starts from zero regardless of any residue.
  always_comb begin
    acc_base    = (state == ACCUM) ? acc      : '0;
    cnt_base    = (state == ACCUM) ? beat_cnt : '0;
    err_base    = (state == ACCUM) ? err_acc  : 1'b0;
    merged_mask = acc_base | beat_mask;
    merged_cnt  = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
    merged_err  = err_base | beat_bad;
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    err_acc_nxt   = err_acc;
    beat_cnt_nxt  = beat_cnt;
    out_mask_nxt  = out_mask;
    out_beats_nxt = out_beats;
    out_err_nxt   = out_err;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          if (in_last) begin
            state_nxt     = OUT;
            out_mask_nxt  = merged_mask;
            out_beats_nxt = merged_cnt;
            out_err_nxt   = merged_err;
            acc_nxt       = '0;
            err_acc_nxt   = 1'b0;
            beat_cnt_nxt  = '0;
          end else begin
            state_nxt    = ACCUM;
            acc_nxt      = merged_mask;
            err_acc_nxt  = merged_err;
            beat_cnt_nxt = merged_cnt;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt    = IDLE;
          acc_nxt      = '0;
          err_acc_nxt  = 1'b0;
          beat_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        acc_nxt      = '0;
        err_acc_nxt  = 1'b0;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      err_acc   <= 1'b0;
      beat_cnt  <= '0;
      out_mask  <= '0;
      out_beats <= '0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      err_acc   <= err_acc_nxt;
      beat_cnt  <= beat_cnt_nxt;
      out_mask  <= out_mask_nxt;
      out_beats <= out_beats_nxt;
      out_err   <= out_err_nxt;
    end
  end

endmodule

// File: tb/tb_dual_priodec_frame.sv
module tb_dual_priodec_frame;
  localparam int WIDTH = 12;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    first;
  logic [CW-1:0]    second;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mask;
  logic [7:0]       out_beats;
  logic             out_err;

  dual_priodec_frame #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .first     (first),
    .second    (second),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_beats (out_beats),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mask;
    int beats;
    int err;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int   m_mask  = 0;
  int   m_beats = 0;
  int   m_err   = 0;
  bit   use_model = 1'b1;
  exp_t dir_exp;
  int   rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input int c);
    return (c >= 1 && c <= WIDTH) ? (1 << (c - 1)) : 0;
  endfunction

  function automatic bit bad(input int f, input int s);
    return (f > WIDTH) || (s > WIDTH) || (s != 0 && f == 0) || (f != 0 && s != 0 && s >= f);
  endfunction

  task automatic model_clear();
    m_mask  = 0;
    m_beats = 0;
    m_err   = 0;
  endtask

  task automatic model_beat(input int f, input int s, input bit l);
    exp_t e;
    m_mask  = m_mask | dec(f) | dec(s);
    m_beats = m_beats + 1;
    if (bad(f, s)) m_err = 1;
    if (l) begin
      if (use_model) begin
        e.mask  = m_mask;
        e.beats = (m_beats > 255) ? 255 : m_beats;
        e.err   = m_err;
      end else begin
        e = dir_exp;
      end
      sb_q.push_back(e);
      use_model = 1'b1;
      model_clear();
    end
  endtask

  task automatic expect_frame(input int em, input int eb, input int ee);
    dir_exp.mask  = em;
    dir_exp.beats = eb;
    dir_exp.err   = ee;
    use_model     = 1'b0;
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 99) < 65);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("out_mask",  32'(out_mask),  32'(e.mask));
        check("out_beats", 32'(out_beats), 32'(e.beats));
        check("out_err",   32'(out_err),   32'(e.err));
      end
    end
  end

  task automatic send_beat(input int f, input int s, input bit l);
    int waited = 0;
    bit done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      first    = f[CW-1:0];
      second   = s[CW-1:0];
      in_last  = l;
      #1;
      if (in_ready) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 2000) begin
          check("accept_timeout", 32'd0, 32'd1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    model_beat(f, s, l);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (l) check("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      first    = CW'($urandom);
      second   = CW'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    model_clear();
    use_model = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int len;
    int f;
    int s;
    reset     = 1'b1;
    in_valid  = 1'b0;
    first     = '0;
    second    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_mask",  32'(out_mask),  32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;

    expect_frame(32'h804, 1, 0);
    send_beat(12, 3, 1);

    send_beat(5, 0, 0);
    check("t2_in_ready_mid", 32'(in_ready), 32'd1);
    expect_frame(32'h111, 2, 0);
    send_beat(9, 1, 1);

    expect_frame(32'h044, 1, 1);
    send_beat(3, 7, 1);
    expect_frame(32'h002, 1, 1);
    send_beat(13, 2, 1);
    expect_frame(32'h008, 1, 1);
    send_beat(0, 4, 1);
    drain();

    rdy_mode = 2;
    expect_frame(32'h804, 1, 0);
    send_beat(12, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      first    = 4'd1;
      second   = 4'd0;
      in_last  = 1'b1;
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_mask",  32'(out_mask),  32'h804);
      check("hold_out_beats", 32'(out_beats), 32'd1);
      check("hold_out_err",   32'(out_err),   32'd0);
      check("hold_in_ready",  32'(in_ready),  32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rdy_mode  = 0;
    @(negedge clk);
    #1;
    check("release_out_valid_low", 32'(out_valid), 32'd0);
    drain();

    send_beat(6, 2, 0);
    do_reset();
    expect_frame(32'h001, 1, 0);
    send_beat(1, 0, 1);
    drain();

    expect_frame(0, 1, 0);
    send_beat(0, 0, 1);
    for (int i = 0; i < 299; i++) send_beat(1, 0, 0);
    expect_frame(32'h001, 255, 0);
    send_beat(1, 0, 1);
    drain();

    rdy_mode = 1;
    for (int fr = 0; fr < 80; fr++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 3) != 0) begin
          f = $urandom_range(1, WIDTH);
          s = $urandom_range(0, f - 1);
        end else begin
          f = $urandom_range(0, 15);
          s = $urandom_range(0, 15);
        end
        send_beat(f, s, (b == len - 1));
      end
    end
    rdy_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
